// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write arbiter and read gate in front of a flagless fifo
// Optional build macro: FIFO_WR_ARB_FIXED_PRI_EN (fixed priority, lowest eligible index wins)
module fifo_wr_arbiter #(
  parameter int N = 10,
  parameter int M = 8,
  parameter int R = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [R-1:0]           req,
  input  logic [R*M-1:0]         req_data,
  output logic [R-1:0]           gnt,
  input  logic                   rd_req,
  output logic                   rd_gnt,
  output logic                   fifo_wr,
  output logic [M-1:0]           fifo_din,
  output logic                   fifo_rd,
  output logic [$clog2(N+1)-1:0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int CW = $clog2(N+1);
  localparam int PW = (R > 1) ? $clog2(R) : 1;

  logic [R-1:0]  elig;
  logic          found;
  logic [PW-1:0] sel;
  logic          wr_go;
  logic          rd_go;

`ifndef FIFO_WR_ARB_FIXED_PRI_EN
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
`endif

  // Pick the winning requester; a requester whose grant is high sits out one edge.
  always_comb begin
    elig  = req & ~gnt;
    found = 1'b0;
    sel   = '0;
`ifdef FIFO_WR_ARB_FIXED_PRI_EN
    for (int i = R - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        sel   = PW'(i);
      end
    end
`else
    for (int k = 0; k < R; k++) begin
      if (!found && elig[(int'(ptr) + k) % R]) begin
        found = 1'b1;
        sel   = PW'((int'(ptr) + k) % R);
      end
    end
`endif
  end

`ifndef FIFO_WR_ARB_FIXED_PRI_EN
  // Pointer moves to the index just after the winner, wrapping at R.
  always_comb begin
    ptr_next = (sel == PW'(R - 1)) ? '0 : sel + PW'(1);
  end
`endif

  // Writes need a free slot; reads need committed data and are spaced by one idle cycle.
  always_comb begin
    wr_go = found && (count < CW'(N));
    rd_go = rd_req && (count != '0) && !rd_gnt;
  end

  // Registered grants, fifo strobes and occupancy tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt      <= '0;
      rd_gnt   <= 1'b0;
      fifo_wr  <= 1'b0;
      fifo_rd  <= 1'b0;
      fifo_din <= '0;
      count    <= '0;
`ifndef FIFO_WR_ARB_FIXED_PRI_EN
      ptr      <= '0;
`endif
    end else begin
      gnt     <= '0;
      fifo_wr <= 1'b0;
      if (wr_go) begin
        gnt      <= {{(R-1){1'b0}}, 1'b1} << sel;
        fifo_wr  <= 1'b1;
        fifo_din <= req_data[int'(sel)*M +: M];
`ifndef FIFO_WR_ARB_FIXED_PRI_EN
        ptr      <= ptr_next;
`endif
      end
      rd_gnt  <= rd_go;
      fifo_rd <= rd_go;
      case ({wr_go, rd_go})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Flags follow the registered count.
  always_comb begin
    full  = (count == CW'(N));
    empty = (count == '0);
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the write port of the team's `fifo` (params N depth, M width) among R requesters using round-robin arbitration.
- Also gates the single read requester onto the FIFO read port.
- The FIFO exposes no flags, so this block tracks occupancy itself. It suppresses writes when full and reads when empty.
- Sits directly in front of `fifo`; drives its wr/din/rd pins.

Parameters:
- N, 10, FIFO depth in entries; must match the attached `fifo`.
- M, 8, data width in bits.
- R, 4, number of write requesters (R >= 2).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- req  input  R  per-requester write request; held until the matching gnt is seen.
- req_data  input  R*M  packed write data; requester i occupies bits [i*M +: M]; held stable with req[i].
- gnt  output  R  one-hot write grant, high for one cycle.
- rd_req  input  1  read request from the consumer.
- rd_gnt  output  1  read accepted, high for one cycle; FIFO dout is valid per the FIFO's read timing.
- fifo_wr  output  1  to fifo wr.
- fifo_din  output  M  to fifo din.
- fifo_rd  output  1  to fifo rd.
- count  output  $clog2(N+1)  entries committed to the FIFO.
- full  output  1  count == N.
- empty  output  1  count == 0.

Behaviour:
- Reset (rst=0), asynchronous:
  - gnt=0, rd_gnt=0, fifo_wr=0, fifo_rd=0, fifo_din=0, count=0, RR pointer=0.
  - full=0, empty=1.
  - Reset mid-operation discards any in-flight grant. The FIFO must be reset in the same window.
- Outputs are registered. gnt, fifo_wr and fifo_din change only on a clk edge.
- Latency: req sampled high at edge k → gnt/fifo_wr/fifo_din asserted during cycle k..k+1. One cycle of latency.
- Eligibility at each edge: eligible[i] = req[i] & ~gnt[i]. A requester whose grant is currently high cannot be re-granted while it is dropping req. Minimum spacing per requester is therefore two cycles.
- Write decision: wr_ok = (count < N).
  - If wr_ok and any eligible bit is set, grant the first eligible index searching ptr, ptr+1, …, ptr+R-1 (mod R).
  - Then set ptr ← granted index + 1 (mod R).
  - With no grant, ptr holds.
- Grant outputs: fifo_wr=1 and fifo_din=req_data[g*M +: M] in the same cycle as gnt[g]=1. Otherwise fifo_wr=0 and fifo_din holds its last value.
- Read decision: rd_ok = rd_req & (count > 0) & ~rd_gnt. If true, rd_gnt=1 and fifo_rd=1 for one cycle. A consumer holding rd_req continuously gets a read every other cycle.
- count is updated on the same edge that asserts fifo_wr/fifo_rd:
  - +1 for a write only.
  - -1 for a read only.
  - unchanged when both are issued in the same cycle.
- Full boundary: at count=N no gnt is issued; requests stay pending. A read at count=N frees a slot, and a write may be granted on the next edge.
- Empty boundary: rd_req is ignored at count=0, even if a write is issued on the same edge. Read-after-write is granted on a later edge.
- count never exceeds N and never wraps below 0.

Optional Feature:
- Macro: FIFO_WR_ARB_FIXED_PRI_EN.
- Defined: fixed priority. The lowest eligible index always wins; the RR pointer is removed.
- Undefined: round-robin as specified above.
- All other behaviour, including latency and full/empty gating, is identical in both builds.

Test Plan:
- Reset: hold rst=0 for 2 cycles with req=4'b1111 → gnt=0, fifo_wr=0, fifo_rd=0, count=0, empty=1, full=0. After release, the first grant goes to requester 0.
- Round-robin: req=4'b1111 continuously, data 0x11/0x22/0x33/0x44, each requester re-raising req after its gnt → grant order 0,1,2,3,0,…; fifo_din follows 0x11,0x22,0x33,0x44; gnt always one-hot. With FIFO_WR_ARB_FIXED_PRI_EN the order becomes 0,1,0,1,…
- Fill: only req[2] active, data = $random, for 30 cycles → exactly 10 writes, then full=1, count=10, no gnt. One rd_req → rd_gnt=1, count=9, then req[2] is granted again and count=10.
- Empty read: rd_req=1 for 3 cycles at count=0 → rd_gnt and fifo_rd stay 0; empty=1 throughout.
- Simultaneous: count=5, req[1] and rd_req rise on the same edge → fifo_wr and fifo_rd both assert in the same cycle; count stays 5.
- Reset mid-burst: drop rst between edges during a gnt[3] pulse → all outputs 0 immediately, count=0. After release with req=4'b1010, the first grant goes to requester 1.
